// File: rtl/reg_bank_wr.sv
// reg_bank_wr: architectural register file (r1..r31, r0 tied to zero) with a single physical
// write port shared by ALU writeback and load writeback.
//
// Ports:
//   clk_i, rst_ni           clock and asynchronous active-low reset
//   alu_we_i/waddr/wdata    ALU writeback (always wins the write port)
//   ld_valid_i, ld_ready_o  load writeback handshake; ld_ready_o = ~pend_valid_o
//   ld_waddr_i, ld_wdata_i  load destination and data
//   pend_valid_o            one-entry pending-load buffer occupied
//   ld_drop_o               one-cycle pulse when a load loses to a same-address ALU write
//   r0_o..r31_o             current register contents (r0_o constant zero)
module reg_bank_wr #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          alu_we_i,
  input  logic [AW-1:0] alu_waddr_i,
  input  logic [DW-1:0] alu_wdata_i,
  input  logic          ld_valid_i,
  output logic          ld_ready_o,
  input  logic [AW-1:0] ld_waddr_i,
  input  logic [DW-1:0] ld_wdata_i,
  output logic          pend_valid_o,
  output logic          ld_drop_o,
  output logic [DW-1:0] r0_o,
  output logic [DW-1:0] r1_o,
  output logic [DW-1:0] r2_o,
  output logic [DW-1:0] r3_o,
  output logic [DW-1:0] r4_o,
  output logic [DW-1:0] r5_o,
  output logic [DW-1:0] r6_o,
  output logic [DW-1:0] r7_o,
  output logic [DW-1:0] r8_o,
  output logic [DW-1:0] r9_o,
  output logic [DW-1:0] r10_o,
  output logic [DW-1:0] r11_o,
  output logic [DW-1:0] r12_o,
  output logic [DW-1:0] r13_o,
  output logic [DW-1:0] r14_o,
  output logic [DW-1:0] r15_o,
  output logic [DW-1:0] r16_o,
  output logic [DW-1:0] r17_o,
  output logic [DW-1:0] r18_o,
  output logic [DW-1:0] r19_o,
  output logic [DW-1:0] r20_o,
  output logic [DW-1:0] r21_o,
  output logic [DW-1:0] r22_o,
  output logic [DW-1:0] r23_o,
  output logic [DW-1:0] r24_o,
  output logic [DW-1:0] r25_o,
  output logic [DW-1:0] r26_o,
  output logic [DW-1:0] r27_o,
  output logic [DW-1:0] r28_o,
  output logic [DW-1:0] r29_o,
  output logic [DW-1:0] r30_o,
  output logic [DW-1:0] r31_o
);

  logic [DW-1:0] regs_q [1:31];

  logic          pend_valid_q, pend_valid_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [DW-1:0] pend_data_q, pend_data_d;
  logic          ld_drop_q, ld_drop_d;

  logic          alu_act;
  logic          ld_new;
  logic          src_vld;
  logic [AW-1:0] src_addr;
  logic [DW-1:0] src_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  assign ld_ready_o = ~pend_valid_q;
  assign alu_act    = alu_we_i && (alu_waddr_i != '0);
  // Loads to r0 are accepted but discarded outright.
  assign ld_new     = ld_valid_i && ld_ready_o && (ld_waddr_i != '0);

  // Pending entry and a freshly accepted load are mutually exclusive (ld_ready is low).
  assign src_vld  = pend_valid_q || ld_new;
  assign src_addr = pend_valid_q ? pend_addr_q : ld_waddr_i;
  assign src_data = pend_valid_q ? pend_data_q : ld_wdata_i;

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    ld_drop_d    = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    if (alu_act) begin
      wr_en   = 1'b1;
      wr_addr = alu_waddr_i;
      wr_data = alu_wdata_i;
      if (src_vld) begin
        if (src_addr == alu_waddr_i) begin
          // ALU result is newer; the load value must never become visible.
          pend_valid_d = 1'b0;
          ld_drop_d    = 1'b1;
        end else begin
          pend_valid_d = 1'b1;
          pend_addr_d  = src_addr;
          pend_data_d  = src_data;
        end
      end
    end else if (src_vld) begin
      wr_en        = 1'b1;
      wr_addr      = src_addr;
      wr_data      = src_data;
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      ld_drop_q    <= 1'b0;
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      ld_drop_q    <= ld_drop_d;
      for (int i = 1; i < 32; i++) begin
        if (wr_en && (wr_addr == AW'(i))) begin
          regs_q[i] <= wr_data;
        end
      end
    end
  end

  assign pend_valid_o = pend_valid_q;
  assign ld_drop_o    = ld_drop_q;

  assign r0_o  = '0;
  assign r1_o  = regs_q[1];
  assign r2_o  = regs_q[2];
  assign r3_o  = regs_q[3];
  assign r4_o  = regs_q[4];
  assign r5_o  = regs_q[5];
  assign r6_o  = regs_q[6];
  assign r7_o  = regs_q[7];
  assign r8_o  = regs_q[8];
  assign r9_o  = regs_q[9];
  assign r10_o = regs_q[10];
  assign r11_o = regs_q[11];
  assign r12_o = regs_q[12];
  assign r13_o = regs_q[13];
  assign r14_o = regs_q[14];
  assign r15_o = regs_q[15];
  assign r16_o = regs_q[16];
  assign r17_o = regs_q[17];
  assign r18_o = regs_q[18];
  assign r19_o = regs_q[19];
  assign r20_o = regs_q[20];
  assign r21_o = regs_q[21];
  assign r22_o = regs_q[22];
  assign r23_o = regs_q[23];
  assign r24_o = regs_q[24];
  assign r25_o = regs_q[25];
  assign r26_o = regs_q[26];
  assign r27_o = regs_q[27];
  assign r28_o = regs_q[28];
  assign r29_o = regs_q[29];
  assign r30_o = regs_q[30];
  assign r31_o = regs_q[31];

endmodule

// File: tb/tb_reg_bank_wr.sv
module tb_reg_bank_wr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_we;
  logic [4:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_waddr;
  logic [31:0] ld_wdata;
  logic        pend_valid;
  logic        ld_drop;
  logic [31:0] r [32];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_bank_wr #(.DW(32), .AW(5)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .alu_we_i(alu_we), .alu_waddr_i(alu_waddr), .alu_wdata_i(alu_wdata),
    .ld_valid_i(ld_valid), .ld_ready_o(ld_ready),
    .ld_waddr_i(ld_waddr), .ld_wdata_i(ld_wdata),
    .pend_valid_o(pend_valid), .ld_drop_o(ld_drop),
    .r0_o(r[0]),   .r1_o(r[1]),   .r2_o(r[2]),   .r3_o(r[3]),
    .r4_o(r[4]),   .r5_o(r[5]),   .r6_o(r[6]),   .r7_o(r[7]),
    .r8_o(r[8]),   .r9_o(r[9]),   .r10_o(r[10]), .r11_o(r[11]),
    .r12_o(r[12]), .r13_o(r[13]), .r14_o(r[14]), .r15_o(r[15]),
    .r16_o(r[16]), .r17_o(r[17]), .r18_o(r[18]), .r19_o(r[19]),
    .r20_o(r[20]), .r21_o(r[21]), .r22_o(r[22]), .r23_o(r[23]),
    .r24_o(r[24]), .r25_o(r[25]), .r26_o(r[26]), .r27_o(r[27]),
    .r28_o(r[28]), .r29_o(r[29]), .r30_o(r[30]), .r31_o(r[31])
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_we = 1'b0; alu_waddr = '0; alu_wdata = '0;
    ld_valid = 1'b0; ld_waddr = '0; ld_wdata = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (r[i] !== 32'h0) begin
        n_fail++; $display("FAIL reset_r%0d: got %h want 0", i, r[i]);
      end
    end
    n_checks++;
    if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready: got %b want 1", ld_ready); end
    n_checks++;
    if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pend: got %b want 0", pend_valid); end
    n_checks++;
    if (ld_drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", ld_drop); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_write();
    alu_we = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'hDEADBEEF;
    tick();
    idle();
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (r[i] !== ((i == 5) ? 32'hDEADBEEF : 32'h0)) begin
        n_fail++; $display("FAIL alu_write_r%0d: got %h", i, r[i]);
      end
    end
  endtask

  task automatic test_r0_protect();
    alu_we = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'hFFFFFFFF;
    ld_valid = 1'b1; ld_waddr = 5'd0; ld_wdata = 32'h1234;
    tick();
    idle();
    n_checks++;
    if (r[0] !== 32'h0) begin n_fail++; $display("FAIL r0_value: got %h want 0", r[0]); end
    n_checks++;
    if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL r0_pend: got %b want 0", pend_valid); end
    n_checks++;
    if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL r0_ready: got %b want 1", ld_ready); end
    tick();
    n_checks++;
    if (ld_drop !== 1'b0) begin n_fail++; $display("FAIL r0_drop: got %b want 0", ld_drop); end
    n_checks++;
    if (r[5] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL r0_r5_kept: got %h", r[5]); end
  endtask

  task automatic test_load_direct();
    ld_valid = 1'b1; ld_waddr = 5'd11; ld_wdata = 32'h33;
    tick();
    idle();
    n_checks++;
    if (r[11] !== 32'h33) begin n_fail++; $display("FAIL load_direct_r11: got %h want 33", r[11]); end
    n_checks++;
    if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL load_direct_pend: got %b want 0", pend_valid); end
  endtask

  task automatic test_contention();
    alu_we = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'h11;
    ld_valid = 1'b1; ld_waddr = 5'd7; ld_wdata = 32'h22;
    tick();
    idle();
    n_checks++;
    if (r[3] !== 32'h11) begin n_fail++; $display("FAIL cont_r3: got %h want 11", r[3]); end
    n_checks++;
    if (r[7] !== 32'h0) begin n_fail++; $display("FAIL cont_r7_early: got %h want 0", r[7]); end
    n_checks++;
    if (pend_valid !== 1'b1) begin n_fail++; $display("FAIL cont_pend: got %b want 1", pend_valid); end
    n_checks++;
    if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL cont_ready: got %b want 0", ld_ready); end
    n_checks++;
    if (ld_drop !== 1'b0) begin n_fail++; $display("FAIL cont_drop: got %b want 0", ld_drop); end
    tick();
    n_checks++;
    if (r[7] !== 32'h22) begin n_fail++; $display("FAIL cont_r7: got %h want 22", r[7]); end
    n_checks++;
    if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL cont_pend_clr: got %b want 0", pend_valid); end
    n_checks++;
    if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL cont_ready_back: got %b want 1", ld_ready); end
  endtask

  task automatic test_override();
    alu_we = 1'b1; alu_waddr = 5'd1; alu_wdata = 32'h1;
    ld_valid = 1'b1; ld_waddr = 5'd9; ld_wdata = 32'hAA;
    tick();
    idle();
    n_checks++;
    if (pend_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_pend_set: got %b want 1", pend_valid); end
    alu_we = 1'b1; alu_waddr = 5'd9; alu_wdata = 32'hBB;
    tick();
    idle();
    n_checks++;
    if (r[9] !== 32'hBB) begin n_fail++; $display("FAIL ovr_r9: got %h want bb", r[9]); end
    n_checks++;
    if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_pend_clr: got %b want 0", pend_valid); end
    n_checks++;
    if (ld_drop !== 1'b1) begin n_fail++; $display("FAIL ovr_drop_pulse: got %b want 1", ld_drop); end
    tick();
    n_checks++;
    if (ld_drop !== 1'b0) begin n_fail++; $display("FAIL ovr_drop_end: got %b want 0", ld_drop); end
    n_checks++;
    if (r[9] !== 32'hBB) begin n_fail++; $display("FAIL ovr_r9_stable: got %h want bb", r[9]); end
  endtask

  task automatic test_backpressure();
    alu_we = 1'b1; alu_waddr = 5'd2; alu_wdata = 32'h2;
    ld_valid = 1'b1; ld_waddr = 5'd6; ld_wdata = 32'h66;
    tick();
    // Buffer holds r6; offer r4 while another ALU write keeps the buffer occupied.
    alu_we = 1'b1; alu_waddr = 5'd8; alu_wdata = 32'h8;
    ld_valid = 1'b1; ld_waddr = 5'd4; ld_wdata = 32'h55;
    n_checks++;
    if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", ld_ready); end
    tick();
    n_checks++;
    if (r[8] !== 32'h8) begin n_fail++; $display("FAIL bp_r8: got %h want 8", r[8]); end
    n_checks++;
    if (r[6] !== 32'h0) begin n_fail++; $display("FAIL bp_r6_held: got %h want 0", r[6]); end
    n_checks++;
    if (pend_valid !== 1'b1) begin n_fail++; $display("FAIL bp_pend_held: got %b want 1", pend_valid); end
    alu_we = 1'b0;
    tick();
    n_checks++;
    if (r[6] !== 32'h66) begin n_fail++; $display("FAIL bp_r6: got %h want 66", r[6]); end
    n_checks++;
    if (r[4] !== 32'h0) begin n_fail++; $display("FAIL bp_r4_early: got %h want 0", r[4]); end
    n_checks++;
    if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b want 1", ld_ready); end
    tick();
    idle();
    n_checks++;
    if (r[4] !== 32'h55) begin n_fail++; $display("FAIL bp_r4: got %h want 55", r[4]); end
    n_checks++;
    if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL bp_pend_end: got %b want 0", pend_valid); end
  endtask

  task automatic test_back_to_back();
    alu_we = 1'b1; alu_waddr = 5'd13; alu_wdata = 32'h1313;
    tick();
    alu_waddr = 5'd14; alu_wdata = 32'h1414;
    n_checks++;
    if (r[13] !== 32'h1313) begin n_fail++; $display("FAIL b2b_r13: got %h want 1313", r[13]); end
    tick();
    alu_waddr = 5'd13; alu_wdata = 32'hCAFE;
    n_checks++;
    if (r[14] !== 32'h1414) begin n_fail++; $display("FAIL b2b_r14: got %h want 1414", r[14]); end
    tick();
    idle();
    n_checks++;
    if (r[13] !== 32'hCAFE) begin n_fail++; $display("FAIL b2b_r13_over: got %h want cafe", r[13]); end
  endtask

  task automatic test_reset_mid();
    alu_we = 1'b1; alu_waddr = 5'd10; alu_wdata = 32'hA;
    ld_valid = 1'b1; ld_waddr = 5'd12; ld_wdata = 32'h77;
    tick();
    idle();
    n_checks++;
    if (pend_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pend_set: got %b want 1", pend_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_pend_async: got %b want 0", pend_valid); end
    n_checks++;
    if (r[10] !== 32'h0) begin n_fail++; $display("FAIL rmid_r10: got %h want 0", r[10]); end
    n_checks++;
    if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", ld_ready); end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if (r[12] !== 32'h0) begin n_fail++; $display("FAIL rmid_r12: got %h want 0", r[12]); end
    n_checks++;
    if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_pend_after: got %b want 0", pend_valid); end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_r0_protect();
    test_load_direct();
    test_contention();
    test_override();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
